// File: rtl/led_sb_ctrl_pkg.sv
// Shared register map for the LED system-bus peripheral, kept here so other
// bus peripherals and software headers can reuse the same addresses.
package led_sb_ctrl_pkg;

    localparam logic [31:0] LED_VAL_ADDR  = 32'h0000_0000;
    localparam logic [31:0] LED_MODE_ADDR = 32'h0000_0004;
    localparam logic [31:0] SOFT_RST_ADDR = 32'h0000_0024;

    localparam logic [31:0] SOFT_RST_KEY  = 32'h0000_0001;

    typedef enum logic {
        MODE_STATIC = 1'b0,
        MODE_BLINK  = 1'b1
    } led_mode_t;

endpackage

// File: rtl/led_sb_ctrl.sv
// LED controller on the system bus: a 16-bit LED value, a static/blink mode
// bit, and a soft-reset register; reads return one cycle after the request.
module led_sb_ctrl
    import led_sb_ctrl_pkg::*;
#(
    parameter int BLINK_PERIOD = 10_000_000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        write_enable_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] write_data_i,
    output logic [31:0] read_data_o,
    output logic [15:0] led_o
);

    localparam int CNT_W = $clog2(2 * BLINK_PERIOD);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(2 * BLINK_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BLINK_PERIOD);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [15:0]      led_val;
    led_mode_t        led_mode;
    logic [CNT_W-1:0] cnt;

    logic      wr;
    logic      rd;
    logic      soft_rst;
    logic      mode_wr;
    led_mode_t mode_next;

    always_comb begin
        wr        = req_i & write_enable_i;
        rd        = req_i & ~write_enable_i;
        soft_rst  = wr && (addr_i == SOFT_RST_ADDR) && (write_data_i == SOFT_RST_KEY);
        // Only the exact values 0 and 1 are legal mode writes.
        mode_wr   = wr && (addr_i == LED_MODE_ADDR) && (write_data_i[31:1] == 31'd0);
        mode_next = mode_wr ? led_mode_t'(write_data_i[0]) : led_mode;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || soft_rst) begin
            led_val     <= 16'h0000;
            led_mode    <= MODE_STATIC;
            cnt         <= '0;
            read_data_o <= 32'h0000_0000;
        end else begin
            if (wr && (addr_i == LED_VAL_ADDR))
                led_val <= write_data_i[15:0];

            led_mode <= mode_next;

            // Counter sits at 0 while static, so entering blink always starts lit;
            // rewriting blink mode leaves the running phase alone.
            if (led_mode == MODE_STATIC || mode_next == MODE_STATIC)
                cnt <= '0;
            else if (cnt == CNT_MAX)
                cnt <= '0;
            else
                cnt <= cnt + CNT_ONE;

            if (rd) begin
                case (addr_i)
                    LED_VAL_ADDR:  read_data_o <= {16'h0000, led_val};
                    LED_MODE_ADDR: read_data_o <= {31'd0, led_mode};
                    default:       read_data_o <= 32'h0000_0000;
                endcase
            end
        end
    end

    // Built only from registered state, so bus inputs never reach the LEDs directly.
    assign led_o = (led_mode == MODE_STATIC || cnt < CNT_HALF) ? led_val : 16'h0000;

endmodule

// File: doc/led_sb_ctrl.md
LED_SB_CTRL -- requirements
Module: led_sb_ctrl

Interface
REQ-001 Parameter BLINK_PERIOD, default 10_000_000, clock cycles per blink half-period (lit or dark); legal range >= 1.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 req_i  input  1  system-bus request; one transaction per asserted cycle.
REQ-005 write_enable_i  input  1  1 = write, 0 = read.
REQ-006 addr_i  input  32  byte address of register within the peripheral.
REQ-007 write_data_i  input  32  write payload.
REQ-008 read_data_o  output  32  registered read payload.
REQ-009 led_o  output  16  LED drive.

Function
REQ-010 Register map: 0x00 LED_VAL (RW, 16 bits); 0x04 LED_MODE (RW, 1 bit); 0x24 SOFT_RST (write-only).
REQ-011 Write 0x00: LED_VAL <= write_data_i[15:0]; bits [31:16] ignored.
REQ-012 Write 0x04: accepted only if write_data_i is 0 or 1; any other value ignored, LED_MODE unchanged.
REQ-013 Write 0x24 with write_data_i == 1: on next edge, all state returns to reset values (REQ-022); other values ignored.
REQ-014 Writes to any other address ignored; no state change.
REQ-015 Read: read_data_o updated one cycle after request: 0x00 -> {16'b0, LED_VAL}; 0x04 -> {31'b0, LED_MODE}; any other address, including 0x24 -> 0.
REQ-016 read_data_o holds last value when no read request is present.
REQ-017 Read of a register in the same cycle it is written is impossible (single transaction per cycle); a read in the cycle after a write returns the new value.
REQ-018 LED_MODE = 0: led_o = LED_VAL; blink counter held at 0.
REQ-019 LED_MODE = 1: counter increments every cycle, 0 .. 2*BLINK_PERIOD-1, then wraps to 0; led_o = LED_VAL while counter < BLINK_PERIOD, else 16'h0000.
REQ-020 Writing LED_MODE 0->1 starts counter at 0 on the following cycle (lit phase first); writing 1 over 1 does not restart counter.
REQ-021 LED_VAL change while blinking takes effect on led_o the cycle after the write, without disturbing counter phase.

Reset
REQ-022 rst_i or accepted SOFT_RST: LED_VAL = 0, LED_MODE = 0, counter = 0, read_data_o = 0, led_o = 0.
REQ-023 rst_i takes priority over any simultaneous bus transaction; that transaction is discarded.
REQ-024 Reset mid-blink cancels blinking immediately; led_o = 0 in the first post-reset cycle.

Structure
REQ-025 Shared package holds register address constants (LED_VAL_ADDR 0x00, LED_MODE_ADDR 0x04, SOFT_RST_ADDR 0x24) for reuse by other bus peripherals and software headers.
REQ-026 Single module; no sub-module; counter width derived as $clog2(2*BLINK_PERIOD).
REQ-027 led_o is registered or derived only from registered state; no combinational path from bus inputs to led_o.

Verification (BLINK_PERIOD = 4)
REQ-028 Write 0x00 = 0xDEADA5A5 -> next cycle led_o = 16'hA5A5; read 0x00 -> read_data_o = 0x0000A5A5 one cycle later.
REQ-029 LED_VAL = 0x00FF, write 0x04 = 1 -> led_o = 0x00FF for 4 cycles, 0x0000 for 4 cycles, repeating; read 0x04 -> 1.
REQ-030 Write 0x04 = 2 -> LED_MODE stays 0; write 0x10 = 0x1234 -> no state change; read 0x10 -> 0.
REQ-031 Blinking with LED_VAL = 0xFFFF, write 0x24 = 1 -> next cycle led_o = 0, reads of 0x00/0x04 return 0.
REQ-032 rst_i asserted in same cycle as write 0x00 = 0x1111 -> LED_VAL = 0 after reset; led_o = 0.
REQ-033 Blinking in dark phase, write 0x04 = 0 -> led_o = LED_VAL next cycle; rewrite 0x04 = 1 -> lit phase restarts for full 4 cycles.
